// File: rtl/vie_regfile_sb.sv
// vie_regfile_sb: architectural register file of the vie MIPS core with a
// per-register scoreboard of in-flight destination writes.
//
// - 32 x 32-bit GPRs, r0 hard-wired to zero.
// - Two combinational read ports serving the ID stage.
// - Writeback arrives on the Vwsbus: [37] we, [36:32] waddr, [31:0] wdata.
// - Each GPR carries a saturating pending-write counter. ID issues increment
//   it, writebacks decrement it, and ID stalls while the counter is non-zero.
// - Retiring a register that has no pending write is a protocol error. It is
//   recorded in the sticky sb_err flag.
//
// Optional build macro VIE_RF_BYPASS_EN:
//   Enables write-through forwarding. A writeback to a register that is being
//   read in the same cycle appears on that read port immediately. The busy
//   flag for that port is masked when the retire drains the last pending
//   write. When the macro is undefined, reads return stored values only.
module vie_regfile_sb #(
    parameter int SB_CNT_W = 2,
    parameter int NREG     = 32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [37:0] wsbus_i,
    input  logic [4:0]  raddr1,
    input  logic [4:0]  raddr2,
    output logic [31:0] rdata1,
    output logic [31:0] rdata2,
    output logic        busy1,
    output logic        busy2,
    input  logic        is_valid,
    input  logic        is_we,
    input  logic [4:0]  is_dest,
    output logic        is_ready,
    output logic        sb_err
);

    localparam logic [SB_CNT_W-1:0] CNT_ZERO = {SB_CNT_W{1'b0}};
    localparam logic [SB_CNT_W-1:0] CNT_ONE  = {{(SB_CNT_W-1){1'b0}}, 1'b1};
    localparam logic [SB_CNT_W-1:0] CNT_MAX  = {SB_CNT_W{1'b1}};

    // Architectural state
    logic [31:0]         regs_r    [0:NREG-1];
    logic [SB_CNT_W-1:0] cnt_r     [0:NREG-1];
    logic [SB_CNT_W-1:0] cnt_nxt_s [0:NREG-1];
    logic                sb_err_r;

    // Decoded writeback bus
    logic        wb_we_s;
    logic [4:0]  wb_addr_s;
    logic [31:0] wb_data_s;
    logic        wr_en_s;

    // Issue / retire qualifiers
    logic        ready_s;
    logic        issue_acc_s;
    logic        same_reg_s;
    logic        err_set_s;

    // Split the writeback bus. Writes to r0 are discarded here, so r0 never
    // changes and never reaches the scoreboard.
    always_comb begin
        wb_we_s   = wsbus_i[37];
        wb_addr_s = wsbus_i[36:32];
        wb_data_s = wsbus_i[31:0];
        wr_en_s   = wb_we_s && (wb_addr_s != 5'd0);
    end

    // Issue handshake. Readiness depends only on the registered counter,
    // never on a same-cycle retire.
    always_comb begin
        if (is_dest == 5'd0) begin
            ready_s = 1'b1;
        end else begin
            ready_s = (cnt_r[is_dest] != CNT_MAX);
        end
        issue_acc_s = is_valid && is_we && ready_s && (is_dest != 5'd0);
        same_reg_s  = issue_acc_s && wr_en_s && (is_dest == wb_addr_s);
        is_ready    = ready_s;
    end

    // Next-state of every pending-write counter: an issue and a retire to the
    // same register cancel, and a retire with nothing pending clamps at zero.
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            if (issue_acc_s && (is_dest == i[4:0]) &&
                !(wr_en_s && (wb_addr_s == i[4:0]))) begin
                cnt_nxt_s[i] = cnt_r[i] + CNT_ONE;
            end else if (wr_en_s && (wb_addr_s == i[4:0]) &&
                         !(issue_acc_s && (is_dest == i[4:0])) &&
                         (cnt_r[i] != CNT_ZERO)) begin
                cnt_nxt_s[i] = cnt_r[i] - CNT_ONE;
            end else begin
                cnt_nxt_s[i] = cnt_r[i];
            end
        end
    end

    // A retire with no pending write is an error, unless an issue to the same
    // register cancels it in this cycle.
    always_comb begin
        if (wr_en_s && !same_reg_s && (cnt_r[wb_addr_s] == CNT_ZERO)) begin
            err_set_s = 1'b1;
        end else begin
            err_set_s = 1'b0;
        end
    end

    // GPR storage: writeback updates the addressed register, and reset wins.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs_r[i] <= 32'h0000_0000;
            end
        end else if (wr_en_s) begin
            regs_r[wb_addr_s] <= wb_data_s;
        end
    end

    // Scoreboard counters and sticky error flag. Everything is cleared by
    // reset, and any issue or retire seen during reset is dropped.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                cnt_r[i] <= CNT_ZERO;
            end
            sb_err_r <= 1'b0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                cnt_r[i] <= cnt_nxt_s[i];
            end
            sb_err_r <= sb_err_r | err_set_s;
        end
    end

    // Combinational read ports, with optional write-through forwarding
    // from the writeback bus.
    always_comb begin
        if (raddr1 == 5'd0) begin
            rdata1 = 32'h0000_0000;
`ifdef VIE_RF_BYPASS_EN
        end else if (wr_en_s && (wb_addr_s == raddr1)) begin
            rdata1 = wb_data_s;
`endif
        end else begin
            rdata1 = regs_r[raddr1];
        end

        if (raddr2 == 5'd0) begin
            rdata2 = 32'h0000_0000;
`ifdef VIE_RF_BYPASS_EN
        end else if (wr_en_s && (wb_addr_s == raddr2)) begin
            rdata2 = wb_data_s;
`endif
        end else begin
            rdata2 = regs_r[raddr2];
        end
    end

    // Busy flags follow the registered counter. With forwarding enabled, a
    // retire that drains the final pending write masks busy in that cycle.
    always_comb begin
        if (raddr1 == 5'd0) begin
            busy1 = 1'b0;
`ifdef VIE_RF_BYPASS_EN
        end else if (wr_en_s && (wb_addr_s == raddr1) && !same_reg_s &&
                     (cnt_r[raddr1] == CNT_ONE)) begin
            busy1 = 1'b0;
`endif
        end else begin
            busy1 = (cnt_r[raddr1] != CNT_ZERO);
        end

        if (raddr2 == 5'd0) begin
            busy2 = 1'b0;
`ifdef VIE_RF_BYPASS_EN
        end else if (wr_en_s && (wb_addr_s == raddr2) && !same_reg_s &&
                     (cnt_r[raddr2] == CNT_ONE)) begin
            busy2 = 1'b0;
`endif
        end else begin
            busy2 = (cnt_r[raddr2] != CNT_ZERO);
        end
    end

    // Error flag output
    always_comb begin
        sb_err = sb_err_r;
    end

endmodule

// File: tb/tb_vie_regfile_sb.sv
// Directed self-checking bench for vie_regfile_sb (handles both builds of
// VIE_RF_BYPASS_EN).
module tb_vie_regfile_sb;

    logic        clock;
    logic        reset;
    logic [37:0] wsbus_i;
    logic [4:0]  raddr1;
    logic [4:0]  raddr2;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
    logic        busy1;
    logic        busy2;
    logic        is_valid;
    logic        is_we;
    logic [4:0]  is_dest;
    logic        is_ready;
    logic        sb_err;

    int n_checks = 0;
    int n_fail   = 0;

    vie_regfile_sb dut (
        .clock    (clock),
        .reset    (reset),
        .wsbus_i  (wsbus_i),
        .raddr1   (raddr1),
        .raddr2   (raddr2),
        .rdata1   (rdata1),
        .rdata2   (rdata2),
        .busy1    (busy1),
        .busy2    (busy2),
        .is_valid (is_valid),
        .is_we    (is_we),
        .is_dest  (is_dest),
        .is_ready (is_ready),
        .sb_err   (sb_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle 1 time unit past the rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset    = 1'b1;
        wsbus_i  = 38'h0;
        raddr1   = 5'd0;
        raddr2   = 5'd0;
        is_valid = 1'b0;
        is_we    = 1'b0;
        is_dest  = 5'd0;
        tick();
        tick();
        reset = 1'b0;
        #1;

        // Reset state: every register reads 0 and nothing is busy.
        for (int i = 0; i < 32; i++) begin
            raddr1 = i[4:0];
            raddr2 = 5'd31 - i[4:0];
            #1;
            chk("rst_rdata1", rdata1, 32'h0);
            chk("rst_rdata2", rdata2, 32'h0);
            chk("rst_busy1", {31'h0, busy1}, 32'h0);
            chk("rst_busy2", {31'h0, busy2}, 32'h0);
        end
        chk("rst_ready", {31'h0, is_ready}, 32'h1);
        chk("rst_sb_err", {31'h0, sb_err}, 32'h0);

        // Write r3 without a pending issue: the data lands, and sb_err is set.
        wsbus_i = {1'b1, 5'd3, 32'hDEAD_BEEF};
        raddr1  = 5'd3;
        #1;
`ifdef VIE_RF_BYPASS_EN
        chk("wr3_same_cycle", rdata1, 32'hDEAD_BEEF);
`else
        chk("wr3_same_cycle", rdata1, 32'h0);
`endif
        tick();
        wsbus_i = 38'h0;
        #1;
        chk("wr3_rdata1", rdata1, 32'hDEAD_BEEF);
        chk("wr3_sb_err", {31'h0, sb_err}, 32'h1);

        // Reset clears the data and the error flag.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("rst2_rdata1", rdata1, 32'h0);
        chk("rst2_sb_err", {31'h0, sb_err}, 32'h0);

        // Write to r0 is ignored and does not set sb_err.
        wsbus_i = {1'b1, 5'd0, 32'h0000_1234};
        raddr1  = 5'd0;
        tick();
        wsbus_i = 38'h0;
        #1;
        chk("r0_rdata1", rdata1, 32'h0);
        chk("r0_sb_err", {31'h0, sb_err}, 32'h0);

        // Three issues to r7 saturate its counter; a fourth is refused.
        raddr1   = 5'd7;
        is_valid = 1'b1;
        is_we    = 1'b1;
        is_dest  = 5'd7;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("r7_ready_pre", {31'h0, is_ready}, 32'h1);
            tick();
        end
        chk("r7_busy_sat", {31'h0, busy1}, 32'h1);
        chk("r7_ready_sat", {31'h0, is_ready}, 32'h0);
        tick();
        chk("r7_ready_4th", {31'h0, is_ready}, 32'h0);
        is_valid = 1'b0;
        wsbus_i  = {1'b1, 5'd7, 32'h0000_0070};
        tick();
        wsbus_i  = 38'h0;
        #1;
        chk("r7_ready_cnt2", {31'h0, is_ready}, 32'h1);
        chk("r7_busy_cnt2", {31'h0, busy1}, 32'h1);
        wsbus_i = {1'b1, 5'd7, 32'h0000_0071};
        tick();
        wsbus_i = 38'h0;
        #1;
        chk("r7_busy_cnt1", {31'h0, busy1}, 32'h1);
        wsbus_i = {1'b1, 5'd7, 32'h0000_0072};
        #1;
`ifdef VIE_RF_BYPASS_EN
        chk("r7_last_busy", {31'h0, busy1}, 32'h0);
        chk("r7_last_data", rdata1, 32'h0000_0072);
`else
        chk("r7_last_busy", {31'h0, busy1}, 32'h1);
        chk("r7_last_data", rdata1, 32'h0000_0071);
`endif
        tick();
        wsbus_i = 38'h0;
        #1;
        chk("r7_busy_done", {31'h0, busy1}, 32'h0);
        chk("r7_rdata_done", rdata1, 32'h0000_0072);
        chk("r7_sb_err", {31'h0, sb_err}, 32'h0);

        // Issue and retire r9 in the same cycle at cnt=1: the count stays at 1.
        raddr1   = 5'd9;
        is_valid = 1'b1;
        is_dest  = 5'd9;
        tick();
        wsbus_i  = {1'b1, 5'd9, 32'h0000_0090};
        #1;
        chk("r9_same_busy_pre", {31'h0, busy1}, 32'h1);
        tick();
        chk("r9_same_busy_post", {31'h0, busy1}, 32'h1);
        is_valid = 1'b0;
        tick();
        wsbus_i  = 38'h0;
        #1;
        chk("r9_drained", {31'h0, busy1}, 32'h0);
        chk("r9_sb_err1", {31'h0, sb_err}, 32'h0);
        // Same case at cnt=0: the count stays 0 and no error is raised.
        is_valid = 1'b1;
        wsbus_i  = {1'b1, 5'd9, 32'h0000_0091};
        tick();
        is_valid = 1'b0;
        wsbus_i  = 38'h0;
        #1;
        chk("r9_zero_busy", {31'h0, busy1}, 32'h0);
        chk("r9_zero_sb_err", {31'h0, sb_err}, 32'h0);
        is_valid = 1'b1;
        tick();
        is_valid = 1'b0;
        #1;
        chk("r9_reissue_busy", {31'h0, busy1}, 32'h1);
        wsbus_i = {1'b1, 5'd9, 32'h0000_0092};
        tick();
        wsbus_i = 38'h0;
        #1;
        chk("r9_reretire_busy", {31'h0, busy1}, 32'h0);
        chk("r9_sb_err2", {31'h0, sb_err}, 32'h0);

        // Issue r10 and retire r11 together: each update applies independently.
        raddr1   = 5'd10;
        raddr2   = 5'd11;
        is_valid = 1'b1;
        is_dest  = 5'd11;
        tick();
        is_dest  = 5'd10;
        wsbus_i  = {1'b1, 5'd11, 32'h0000_0B0B};
        tick();
        is_valid = 1'b0;
        wsbus_i  = 38'h0;
        #1;
        chk("diff_busy10", {31'h0, busy1}, 32'h1);
        chk("diff_busy11", {31'h0, busy2}, 32'h0);
        chk("diff_rdata11", rdata2, 32'h0000_0B0B);
        chk("diff_sb_err", {31'h0, sb_err}, 32'h0);

        // Retire r12 with nothing pending: sb_err is set and stays set.
        raddr1  = 5'd12;
        wsbus_i = {1'b1, 5'd12, 32'h0000_0C0C};
        tick();
        wsbus_i = 38'h0;
        #1;
        chk("r12_sb_err", {31'h0, sb_err}, 32'h1);
        chk("r12_busy", {31'h0, busy1}, 32'h0);
        tick();
        tick();
        chk("r12_sb_err_sticky", {31'h0, sb_err}, 32'h1);
        is_valid = 1'b1;
        is_dest  = 5'd12;
        tick();
        is_valid = 1'b0;
        wsbus_i  = {1'b1, 5'd12, 32'h0000_0C0D};
        tick();
        wsbus_i  = 38'h0;
        #1;
        chk("r12_cnt_clamped", {31'h0, busy1}, 32'h0);
        chk("r12_sb_err_hold", {31'h0, sb_err}, 32'h1);

        // Forwarding case: with cnt[4]=1, retire r4 while port 2 reads it.
        raddr2   = 5'd4;
        is_valid = 1'b1;
        is_dest  = 5'd4;
        tick();
        is_valid = 1'b0;
        wsbus_i  = {1'b1, 5'd4, 32'h1111_2222};
        tick();
        is_valid = 1'b1;
        wsbus_i  = 38'h0;
        tick();
        is_valid = 1'b0;
        wsbus_i  = {1'b1, 5'd4, 32'hA5A5_A5A5};
        #1;
`ifdef VIE_RF_BYPASS_EN
        chk("byp_rdata2", rdata2, 32'hA5A5_A5A5);
        chk("byp_busy2", {31'h0, busy2}, 32'h0);
`else
        chk("byp_rdata2", rdata2, 32'h1111_2222);
        chk("byp_busy2", {31'h0, busy2}, 32'h1);
`endif
        tick();
        wsbus_i = 38'h0;
        #1;
        chk("byp_rdata2_post", rdata2, 32'hA5A5_A5A5);
        chk("byp_busy2_post", {31'h0, busy2}, 32'h0);

        // Reset mid-operation: pending r20 is discarded, and a write to r21 and
        // an issue to r22 presented during reset are dropped.
        is_valid = 1'b1;
        is_dest  = 5'd20;
        tick();
        reset    = 1'b1;
        is_dest  = 5'd22;
        wsbus_i  = {1'b1, 5'd21, 32'h2121_2121};
        tick();
        reset    = 1'b0;
        is_valid = 1'b0;
        wsbus_i  = 38'h0;
        raddr1   = 5'd20;
        raddr2   = 5'd21;
        #1;
        chk("mid_rst_busy20", {31'h0, busy1}, 32'h0);
        chk("mid_rst_rdata21", rdata2, 32'h0);
        raddr1 = 5'd22;
        raddr2 = 5'd4;
        #1;
        chk("mid_rst_busy22", {31'h0, busy1}, 32'h0);
        chk("mid_rst_rdata4", rdata2, 32'h0);
        chk("mid_rst_sb_err", {31'h0, sb_err}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
